// File: rtl/imdct_twiddle_rotator.sv
// ---------------------------------------------------------------------------
// imdct_twiddle_rotator
//   Pre/post-twiddle rotation stage of the IMDCT. Each complex input sample
//   x[k] is multiplied by a twiddle (C,S) pair read from a 257-entry ROM. The
//   512-point frame is covered by mirror symmetry: for k > 256 the entry at
//   512-k is read with C and S swapped.
//
//   Pipeline (all stages advance together on adv):
//     S0  accept: k_eff -> rom_addr, sample/mirror/first/last captured
//     S1  rom_dout valid: four DW x 32 signed products registered
//     S2  sum/difference, round (+2^30), >>>31, fit to DW -> out_* regs
//   Latency accept -> out_valid is 3 cycles with no stall; 1 sample/cycle.
//
//   Optional feature macro: IMDCT_ROT_SAT_EN
//     defined     : shifted result clamped to [-2^(DW-1), 2^(DW-1)-1]
//     not defined : shifted result wraps (low DW bits kept)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     input handshake; in_first restarts k at 0
//   in_re, in_im          input sample, signed DW
//   out_valid/out_ready   output handshake
//   out_first, out_last   sample is k==0 / k==FRAME-1
//   out_re, out_im        rotated sample, signed DW
//   rom_en, rom_addr      ROM read port (1-cycle latency, dout held if !en)
//   rom_dout              {C[63:32], S[31:0]}, signed Q1.31
// ---------------------------------------------------------------------------
module imdct_twiddle_rotator #(
    parameter int DW    = 24,
    parameter int FRAME = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic [DW-1:0]            in_re,
    input  logic [DW-1:0]            in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last,
    output logic [DW-1:0]            out_re,
    output logic [DW-1:0]            out_im,
    output logic                     rom_en,
    output logic [$clog2(FRAME)-1:0] rom_addr,
    input  logic [63:0]              rom_dout
);

    localparam int KW     = $clog2(FRAME);
    localparam int HALF   = FRAME / 2;
    localparam int PW     = DW + 32;     // single product width
    localparam int SW     = DW + 33;     // sum of two products
    localparam int STAGES = 2;

`ifdef IMDCT_ROT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [SW-1:0] RND  = SW'(1) << 30;
    localparam logic signed [SW-1:0] MAXV = (SW'(1) << (DW-1)) - SW'(1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 mirror;
        logic                 first;
        logic                 last;
    } s1_t;

    typedef struct packed {
        logic signed [PW-1:0] p_rc;   // x_re * c
        logic signed [PW-1:0] p_is;   // x_im * s
        logic signed [PW-1:0] p_ic;   // x_im * c
        logic signed [PW-1:0] p_rs;   // x_re * s
        logic                 first;
        logic                 last;
    } s2_t;

    // vld_pipe_q[0]=S1, [1]=S2, [STAGES]=output register
    logic [STAGES:0]   vld_pipe_q;
    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    logic [KW-1:0]     k_q, k_d, k_eff;
    logic              adv, accept, mirror;
    logic [DW-1:0]     out_re_q, out_im_q, out_re_d, out_im_d;
    logic              out_first_q, out_last_q;
    logic signed [31:0] c_sel, s_sel;
    logic signed [SW-1:0] re_sh, im_sh;

    function automatic logic signed [PW-1:0] smul(input logic signed [DW-1:0] a,
                                                  input logic signed [31:0]   b);
        logic signed [PW-1:0] ae, be;
        ae = PW'(a);
        be = PW'(b);
        return ae * be;
    endfunction

    function automatic logic [DW-1:0] fit(input logic signed [SW-1:0] v);
        if (SAT_EN && (v > MAXV)) return MAXV[DW-1:0];
        if (SAT_EN && (v < MINV)) return MINV[DW-1:0];
        return v[DW-1:0];
    endfunction

    // A full output register that is not being drained freezes everything,
    // including the ROM read, so rom_dout stays paired with the S1 sample.
    assign adv      = ~vld_pipe_q[STAGES] | out_ready;
    assign in_ready = adv;
    assign rom_en   = adv;
    assign accept   = in_valid & adv;

    // S0: frame index and mirrored ROM address. FRAME is a power of two, so
    // FRAME-k_eff equals -k_eff modulo 2^KW.
    always_comb begin
        k_eff    = in_first ? '0 : k_q;
        mirror   = (k_eff > KW'(HALF));
        rom_addr = mirror ? (KW'(0) - k_eff) : k_eff;
        k_d      = k_q;
        if (accept) k_d = (k_eff == KW'(FRAME-1)) ? '0 : k_eff + 1'b1;

        s1_d.re     = in_re;
        s1_d.im     = in_im;
        s1_d.mirror = mirror;
        s1_d.first  = (k_eff == '0);
        s1_d.last   = (k_eff == KW'(FRAME-1));
    end

    // S1: mirrored half of the table uses the swapped pair (S,C).
    always_comb begin
        c_sel      = s1_q.mirror ? rom_dout[31:0]  : rom_dout[63:32];
        s_sel      = s1_q.mirror ? rom_dout[63:32] : rom_dout[31:0];
        s2_d.p_rc  = smul(s1_q.re, c_sel);
        s2_d.p_is  = smul(s1_q.im, s_sel);
        s2_d.p_ic  = smul(s1_q.im, c_sel);
        s2_d.p_rs  = smul(s1_q.re, s_sel);
        s2_d.first = s1_q.first;
        s2_d.last  = s1_q.last;
    end

    // S2: complex multiply-accumulate, round-half-up and drop Q1.31 scale.
    always_comb begin
        re_sh = ($signed({s2_q.p_rc[PW-1], s2_q.p_rc})
               + $signed({s2_q.p_is[PW-1], s2_q.p_is}) + RND) >>> 31;
        im_sh = ($signed({s2_q.p_ic[PW-1], s2_q.p_ic})
               - $signed({s2_q.p_rs[PW-1], s2_q.p_rs}) + RND) >>> 31;
        out_re_d = fit(re_sh);
        out_im_d = fit(im_sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            k_q         <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (adv) begin
            // Bubbles travel down the pipe as cleared valid bits.
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], accept};
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            k_q         <= k_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_first_q <= s2_q.first & vld_pipe_q[1];
            out_last_q  <= s2_q.last  & vld_pipe_q[1];
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_imdct_twiddle_rotator.sv
// ---------------------------------------------------------------------------
// tb_imdct_twiddle_rotator
//   Directed + randomized bench. A 257x64 twiddle ROM model with 1-cycle
//   latency feeds the DUT; a reference model computes every expected output
//   from the frame index rules with integer arithmetic and queues it in
//   order. Outputs are compared whenever out_valid is high.
// ---------------------------------------------------------------------------
module tb_imdct_twiddle_rotator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b1;
    logic [23:0] in_re = '0, in_im = '0;
    logic        in_ready, out_valid, out_first, out_last, rom_en;
    logic [23:0] out_re, out_im;
    logic [8:0]  rom_addr;
    logic [63:0] rom_dout = '0;

    logic [63:0] rom [0:256];

    typedef struct {
        logic [23:0] re;
        logic [23:0] im;
        logic        first;
        logic        last;
    } exp_t;

    exp_t expq[$];
    int   k_model = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    imdct_twiddle_rotator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last),
        .out_re(out_re), .out_im(out_im),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [23:0] fit(input longint v);
`ifdef IMDCT_ROT_SAT_EN
        if (v > 64'sd8388607)  return 24'h7FFFFF;
        if (v < -64'sd8388608) return 24'h800000;
`endif
        return v[23:0];
    endfunction

    // Rotation of x by the twiddle for frame index k, straight from the table rules.
    function automatic exp_t model(input logic [23:0] r, input logic [23:0] i, input int k);
        exp_t        e;
        int          addr;
        logic [63:0] w;
        longint      xr, xi, c, s, vr, vi;
        addr = (k <= 256) ? k : 512 - k;
        w    = rom[addr];
        if (k <= 256) begin
            c = longint'($signed(w[63:32])); s = longint'($signed(w[31:0]));
        end else begin
            c = longint'($signed(w[31:0]));  s = longint'($signed(w[63:32]));
        end
        xr = longint'($signed(r));
        xi = longint'($signed(i));
        vr = (xr * c + xi * s + (64'sd1 <<< 30)) >>> 31;
        vi = (xi * c - xr * s + (64'sd1 <<< 30)) >>> 31;
        e.re = fit(vr);
        e.im = fit(vi);
        e.first = (k == 0);
        e.last  = (k == 511);
        return e;
    endfunction

    // One clock: drive inputs, check the combinational port and the current
    // output register against the model, then step to the next falling edge.
    task automatic tick(input bit v, input bit f, input logic [23:0] r,
                        input logic [23:0] i, input bit rdy);
        bit   adv_e;
        int   keff, addr;
        exp_t e;
        in_valid = v; in_first = f; in_re = r; in_im = i; out_ready = rdy;
        #1;
        adv_e = !out_valid || rdy;
        chk("in_ready", in_ready, adv_e);
        chk("rom_en", rom_en, adv_e);
        if (out_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                chk("out_re", out_re, expq[0].re);
                chk("out_im", out_im, expq[0].im);
                chk("out_first", out_first, expq[0].first);
                chk("out_last", out_last, expq[0].last);
                if (rdy) void'(expq.pop_front());
            end
        end
        if (v && adv_e) begin
            keff = f ? 0 : k_model;
            addr = (keff <= 256) ? keff : 512 - keff;
            chk("rom_addr", rom_addr, addr);
            expq.push_back(model(r, i, keff));
            k_model = (keff == 511) ? 0 : keff + 1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a <= 256; a++) rom[a] = {$urandom, $urandom};
        rom[0]   = {32'h40000000, 32'h00000000};
        rom[256] = {32'h5A82799A, 32'h5A82799A};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rom_en", rom_en, 1);
        @(negedge clk);

        // First sample at k=0, 3-cycle latency, scaled by C=0.5
        tick(1, 1, 24'h100000, 24'h0, 1);
        chk("lat_c1", out_valid, 0);
        tick(0, 0, 24'h0, 24'h0, 1);
        chk("lat_c2", out_valid, 0);
        tick(0, 0, 24'h0, 24'h0, 1);
        chk("lat_valid", out_valid, 1);
        chk("lat_re", out_re, 24'h080000);
        chk("lat_im", out_im, 24'h0);
        chk("lat_first", out_first, 1);
        tick(0, 0, 24'h0, 24'h0, 1);

        // Full frame; k=256 carries the full-scale sample
        for (int n = 0; n < 512; n++) begin
            if (n == 256) tick(1, n == 0, 24'h7FFFFF, 24'h7FFFFF, 1);
            else          tick(1, n == 0, 24'h100000, 24'h0, 1);
        end
        chk("wrap_k", k_model, 0);

        // Backpressure: 5 stalled cycles mid-stream
        for (int n = 0; n < 6; n++) tick(1, 0, 24'($urandom), 24'($urandom), 1);
        for (int n = 0; n < 5; n++) tick(1, 0, 24'($urandom), 24'($urandom), 0);
        for (int n = 0; n < 6; n++) tick(1, 0, 24'($urandom), 24'($urandom), 1);

        // Randomized traffic with random valid/ready and occasional restarts
        for (int n = 0; n < 600; n++)
            tick(($urandom % 4) != 0, ($urandom % 64) == 0,
                 24'($urandom), 24'($urandom), ($urandom % 3) != 0);
        for (int n = 0; n < 6; n++) tick(0, 0, 24'h0, 24'h0, 1);
        chk("drain_empty", expq.size(), 0);

        // Reset with three samples in flight
        for (int n = 0; n < 3; n++) tick(1, 0, 24'($urandom), 24'($urandom), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        expq.delete();
        k_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) tick(0, 0, 24'h0, 24'h0, 1);
        tick(1, 1, 24'h123456, 24'h654321, 1);
        for (int n = 0; n < 5; n++) tick(0, 0, 24'h0, 24'h0, 1);
        chk("post_rst_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
